// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags, overflow/underflow pulses and optional FWFT read port.
// Latency: flags/count valid the cycle after the causing edge; FWFT=0 data one cycle after read, FWFT=1 head word shown combinationally.
// Backpressure: writes when full (without a same-cycle pop) and reads when empty are dropped and reported by a one-cycle pulse.
module fifo_flags #(
    parameter int D_W   = 8,
    parameter int AD_W  = 4,
    parameter int AF_TH = 14,
    parameter int AE_TH = 2,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic             read,
    input  logic [D_W-1:0]   data_in,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AD_W:0]    count,
    output logic             overflow,
    output logic             underflow,
    output logic [D_W-1:0]   data_out
);

    localparam int DEPTH = 1 << AD_W;

    // Configuration guards: a bad threshold or mode stops elaboration.
    generate
        if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af_th
            $error("fifo_flags: AF_TH out of range 1..DEPTH");
        end
        if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_bad_ae_th
            $error("fifo_flags: AE_TH out of range 0..DEPTH-1");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("fifo_flags: FWFT must be 0 or 1");
        end
    endgenerate

    localparam logic [AD_W:0] DEPTH_C = (AD_W+1)'(DEPTH);
    localparam logic [AD_W:0] AF_C    = (AD_W+1)'(AF_TH);
    localparam logic [AD_W:0] AE_C    = (AD_W+1)'(AE_TH);

    logic [D_W-1:0]  mem [DEPTH];
    logic [AD_W-1:0] wr_ptr;
    logic [AD_W-1:0] rd_ptr;
    logic            rd_ok;
    logic            wr_ok;
    logic [AD_W:0]   count_next;

    // Accept/reject decisions; a pop frees a slot so a full FIFO can take a same-cycle push.
    always_comb begin
        rd_ok      = read & ~empty;
        wr_ok      = write & (~full | rd_ok);
        count_next = count + (AD_W+1)'(wr_ok) - (AD_W+1)'(rd_ok);
    end

    // Storage array; not cleared by reset, but reset blocks the write of that cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, flags and error pulses, all registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AD_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AD_W'(1);
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            overflow     <= write & ~wr_ok;
            underflow    <= read & ~rd_ok;
        end
    end

    generate
        if (FWFT == 1) begin : g_fwft
            // Head word is shown directly; zero while empty so reset leaves data_out at 0.
            always_comb begin
                data_out = empty ? '0 : mem[rd_ptr];
            end
        end else begin : g_reg_read
            logic [D_W-1:0] dout_q;

            // Registered read: capture the head word on an accepted pop, hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: drives a registered-read and an FWFT instance with identical stimulus.
// Latency: every stimulus step is one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: a queue scoreboard tracks accepted words and predicts flags, pulses and read data.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       read;
    logic [7:0] data_in;

    logic       full0, empty0, afull0, aempty0, ovf0, unf0;
    logic [4:0] count0;
    logic [7:0] dout0;
    logic       full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [4:0] count1;
    logic [7:0] dout1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] sb[$];
    int         m_count = 0;
    logic [7:0] m_dout  = 8'h00;

    always #5 clk = ~clk;

    fifo_flags #(.D_W(8), .AD_W(4), .AF_TH(14), .AE_TH(2), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
        .full(full0), .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
        .count(count0), .overflow(ovf0), .underflow(unf0), .data_out(dout0)
    );

    fifo_flags #(.D_W(8), .AD_W(4), .AF_TH(14), .AE_TH(2), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
        .full(full1), .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
        .count(count1), .overflow(ovf1), .underflow(unf1), .data_out(dout1)
    );

    // Drive one clock of stimulus and advance the scoreboard to the post-edge state.
    task automatic cycle(input bit r_st, input bit w, input bit r, input logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        rst = r_st; write = w; read = r; data_in = d;
        if (r_st) begin
            sb.delete();
            m_count = 0;
            m_dout  = 8'h00;
        end else begin
            rd_ok = r && (m_count != 0);
            wr_ok = w && ((m_count != 16) || rd_ok);
            if (rd_ok) m_dout = sb.pop_front();
            if (wr_ok) sb.push_back(d);
            m_count = m_count + int'(wr_ok) - int'(rd_ok);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        tests_run++; if (count0 !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count0); end
        tests_run++; if (empty0 !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", empty0); end
        tests_run++; if (aempty0 !== 1'b1) begin tests_failed++; $display("FAIL reset_almost_empty: got %b want 1", aempty0); end
        tests_run++; if (full0 !== 1'b0 || afull0 !== 1'b0) begin tests_failed++; $display("FAIL reset_full_flags: got %b%b want 00", full0, afull0); end
        tests_run++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got ovf=%b unf=%b want 0 0", ovf0, unf0); end
        tests_run++; if (dout0 !== 8'h00) begin tests_failed++; $display("FAIL reset_dout: got %h want 00", dout0); end
        tests_run++; if (empty1 !== 1'b1 || count1 !== 5'd0) begin tests_failed++; $display("FAIL reset_fwft: got empty=%b count=%0d want 1 0", empty1, count1); end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++; if (unf0 !== 1'b1) begin tests_failed++; $display("FAIL reset_first_read_underflow: got %b want 1", unf0); end
        tests_run++; if (count0 !== 5'd0) begin tests_failed++; $display("FAIL reset_underflow_count: got %0d want 0", count0); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++; if (unf0 !== 1'b0) begin tests_failed++; $display("FAIL reset_underflow_pulse_end: got %b want 0", unf0); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'(i));
            tests_run++; if (count0 !== 5'(m_count)) begin tests_failed++; $display("FAIL fill_count_%0d: got %0d want %0d", i, count0, m_count); end
            tests_run++; if (afull0 !== (i >= 14)) begin tests_failed++; $display("FAIL fill_almost_full_%0d: got %b want %b", i, afull0, (i >= 14)); end
            tests_run++; if (full0 !== (i == 16)) begin tests_failed++; $display("FAIL fill_full_%0d: got %b want %b", i, full0, (i == 16)); end
            tests_run++; if (dout1 !== 8'h01) begin tests_failed++; $display("FAIL fill_fwft_head_%0d: got %h want 01", i, dout1); end
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h11);
        tests_run++; if (ovf0 !== 1'b1) begin tests_failed++; $display("FAIL fill_overflow: got %b want 1", ovf0); end
        tests_run++; if (count0 !== 5'd16) begin tests_failed++; $display("FAIL fill_overflow_count: got %0d want 16", count0); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++; if (ovf0 !== 1'b0) begin tests_failed++; $display("FAIL fill_overflow_pulse_end: got %b want 0", ovf0); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            tests_run++; if (dout0 !== 8'(i + 1) || dout0 !== m_dout) begin tests_failed++; $display("FAIL drain_data_%0d: got %h want %h", i, dout0, 8'(i + 1)); end
            tests_run++; if (count0 !== 5'(15 - i)) begin tests_failed++; $display("FAIL drain_count_%0d: got %0d want %0d", i, count0, 15 - i); end
            tests_run++; if (aempty0 !== ((15 - i) <= 2)) begin tests_failed++; $display("FAIL drain_almost_empty_%0d: got %b want %b", i, aempty0, ((15 - i) <= 2)); end
            if (i < 15) begin
                tests_run++; if (dout1 !== 8'(i + 2)) begin tests_failed++; $display("FAIL drain_fwft_head_%0d: got %h want %h", i, dout1, 8'(i + 2)); end
            end
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++; if (unf0 !== 1'b1) begin tests_failed++; $display("FAIL drain_underflow: got %b want 1", unf0); end
        tests_run++; if (dout0 !== 8'h10) begin tests_failed++; $display("FAIL drain_dout_hold: got %h want 10", dout0); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++; if (unf0 !== 1'b0 || empty0 !== 1'b1) begin tests_failed++; $display("FAIL drain_idle: got unf=%b empty=%b want 0 1", unf0, empty0); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        tests_run++; if (full0 !== 1'b1) begin tests_failed++; $display("FAIL full_rw_prefill: got full=%b want 1", full0); end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'(8'h40 + k));
            tests_run++; if (count0 !== 5'd16 || full0 !== 1'b1) begin tests_failed++; $display("FAIL full_rw_count_%0d: got count=%0d full=%b want 16 1", k, count0, full0); end
            tests_run++; if (ovf0 !== 1'b0) begin tests_failed++; $display("FAIL full_rw_overflow_%0d: got %b want 0", k, ovf0); end
            tests_run++; if (dout0 !== 8'(8'h20 + k)) begin tests_failed++; $display("FAIL full_rw_data_%0d: got %h want %h", k, dout0, 8'(8'h20 + k)); end
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            tests_run++; if (dout0 !== m_dout) begin tests_failed++; $display("FAIL full_rw_drain_%0d: got %h want %h", i, dout0, m_dout); end
        end
        cycle(1'b0, 1'b1, 1'b1, 8'h77);
        tests_run++; if (count0 !== 5'd1 || empty0 !== 1'b0) begin tests_failed++; $display("FAIL empty_rw_count: got count=%0d empty=%b want 1 0", count0, empty0); end
        tests_run++; if (unf0 !== 1'b1) begin tests_failed++; $display("FAIL empty_rw_underflow: got %b want 1", unf0); end
        tests_run++; if (dout1 !== 8'h77) begin tests_failed++; $display("FAIL empty_rw_fwft: got %h want 77", dout1); end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++; if (dout0 !== 8'h77 || empty0 !== 1'b1) begin tests_failed++; $display("FAIL empty_rw_pop: got %h empty=%b want 77 1", dout0, empty0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int k = 0; k < 40; k++) begin
            d = 8'($urandom_range(0, 255));
            cycle(1'b0, 1'b1, 1'b0, d);
            tests_run++; if (count0 !== 5'd1) begin tests_failed++; $display("FAIL b2b_count_w_%0d: got %0d want 1", k, count0); end
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            tests_run++; if (dout0 !== d || dout0 !== m_dout) begin tests_failed++; $display("FAIL b2b_data_%0d: got %h want %h", k, dout0, d); end
            tests_run++; if (count0 !== 5'd0) begin tests_failed++; $display("FAIL b2b_count_r_%0d: got %0d want 0", k, count0); end
        end
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
        tests_run++; if (count0 !== 5'd9) begin tests_failed++; $display("FAIL b2b_prereset_count: got %0d want 9", count0); end
        cycle(1'b1, 1'b1, 1'b1, 8'hEE);
        tests_run++; if (count0 !== 5'd0 || empty0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_midreset: got count=%0d empty=%b want 0 1", count0, empty0); end
        tests_run++; if (count1 !== 5'd0 || empty1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_midreset_fwft: got count=%0d empty=%b want 0 1", count1, empty1); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++; if (empty0 !== 1'b1 || count0 !== 5'd0) begin tests_failed++; $display("FAIL b2b_after_reset: got count=%0d empty=%b want 0 1", count0, empty0); end
    endtask

    task automatic test_fwft();
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        tests_run++; if (empty1 !== 1'b0) begin tests_failed++; $display("FAIL fwft_empty: got %b want 0", empty1); end
        tests_run++; if (dout1 !== 8'hA5) begin tests_failed++; $display("FAIL fwft_head: got %h want a5", dout1); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++; if (dout1 !== 8'hA5 || count1 !== 5'd1) begin tests_failed++; $display("FAIL fwft_hold: got %h count=%0d want a5 1", dout1, count1); end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++; if (empty1 !== 1'b1 || count1 !== 5'd0) begin tests_failed++; $display("FAIL fwft_pop_empty: got empty=%b count=%0d want 1 0", empty1, count1); end
        tests_run++; if (dout0 !== 8'hA5) begin tests_failed++; $display("FAIL fwft_regread_data: got %h want a5", dout0); end
        tests_run++; if (unf1 !== 1'b0) begin tests_failed++; $display("FAIL fwft_no_underflow: got %b want 0", unf1); end
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; read = 1'b0; data_in = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_back_to_back();
        test_fwft();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
